// File: rtl/mul_unit_arbiter_pkg.sv
// Shared types and default sizing for the multiply-unit arbiter slice.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  localparam int unsigned DEF_N       = 4;
  localparam int unsigned DEF_W       = 32;
  localparam int unsigned DEF_TIMEOUT = 1024;

endpackage

// File: rtl/mul_unit_arbiter_if.sv
// Requester-side request/response bus of the multiply-unit arbiter.
interface mul_unit_arbiter_if
  import mul_arb_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_result, resp_err
  );

endinterface

// File: rtl/mul_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_unit_arbiter.sv
// Round-robin sharing of one start/done compute unit among N requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mul_unit_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  mul_unit_arbiter_if.slave   bus,
  output logic                busy,
  output logic                unit_start,
  output logic [W-1:0]        unit_a,
  output logic [W-1:0]        unit_b,
  input  logic                unit_done,
  input  logic [W-1:0]        unit_result,
  output logic                unit_clear
);

  localparam int unsigned PW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("mul_unit_arbiter: N must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mul_unit_arbiter: TIMEOUT must be at least 1");
  end

  state_t        state, state_nx;
  logic [PW-1:0] ptr, owner, grant_idx;
  logic [N-1:0]  grant;
  logic          any;
  logic          done_q;
  logic          accept, complete, timeout;
  logic [N-1:0]  resp_valid_q;
  logic [W-1:0]  resp_result_q;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  assign accept   = (state == IDLE) && any;
  // Rising edge only, so a level done left high by the previous job is ignored.
  assign complete = (state == WAIT) && unit_done && !done_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    unit_start    = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = grant;
        if (any) state_nx = START;
      end
      START: begin
        unit_start = 1'b1;
        busy       = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (complete || timeout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      owner         <= '0;
      done_q        <= 1'b0;
      unit_a        <= '0;
      unit_b        <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
    end else begin
      done_q       <= unit_done;
      resp_valid_q <= '0;
      if (accept) begin
        owner  <= grant_idx;
        ptr    <= PW'((32'(grant_idx) + 1) % N);
        unit_a <= bus.req_a[32'(grant_idx) * W +: W];
        unit_b <= bus.req_b[32'(grant_idx) * W +: W];
      end
      if (complete) begin
        resp_valid_q[owner] <= 1'b1;
        resp_result_q       <= unit_result;
      end else if (timeout) begin
        resp_valid_q[owner] <= 1'b1;
        resp_result_q       <= '0;
      end
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q, clear_q;

  // Counter sits at zero outside WAIT, so it is cleared on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout = (state == WAIT) && !complete && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      err_q   <= timeout;
      clear_q <= timeout;
    end
  end

  assign bus.resp_err = err_q;
  assign unit_clear   = clear_q;
`else
  assign timeout      = 1'b0;
  assign bus.resp_err = 1'b0;
  assign unit_clear   = 1'b0;
`endif

endmodule

// File: tb/tb_mul_unit_arbiter.sv
// Randomized bench for mul_unit_arbiter against a transaction-level reference model.
module tb_mul_unit_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned TO  = 16;
  localparam int unsigned LAT = 5;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } job_t;
  typedef struct { int unsigned owner; logic [W-1:0] result; logic err; } resp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         busy, unit_start, unit_done, unit_clear;
  logic [W-1:0] unit_a, unit_b, unit_result;

  always #5 clk = ~clk;

  mul_unit_arbiter_if #(.N(N), .W(W)) bus ();

  mul_unit_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .unit_start  (unit_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .unit_clear  (unit_clear)
  );

  // Behavioural unit: done rises LAT cycles after start and stays high until the next start.
  int unsigned u_cnt;
  bit          never_done = 1'b0;
  always @(posedge clk) begin
    if (reset || unit_clear) begin
      u_cnt       <= 0;
      unit_done   <= 1'b0;
      unit_result <= '0;
    end else if (unit_start) begin
      u_cnt       <= 1;
      unit_done   <= 1'b0;
      unit_result <= unit_a * unit_b;
    end else if (u_cnt != 0) begin
      if (u_cnt == LAT - 1) begin
        u_cnt     <= 0;
        unit_done <= !never_done;
      end else begin
        u_cnt <= u_cnt + 1;
      end
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: arbiter free/busy, rotating pointer, expected product per job.
  bit           m_free, m_start, m_wait, m_resp, m_err, prev_done, withdraw_en;
  int unsigned  m_ptr, m_owner, m_wcnt;
  logic [W-1:0] m_ua, m_ub, m_hold;
  logic [N-1:0] acc_mask;
  job_t         jq[N][$];
  int unsigned  grant_log[$];
  resp_t        resp_log[$];

  task automatic model_reset();
    m_free = 1'b1; m_start = 1'b0; m_wait = 1'b0; m_resp = 1'b0; m_err = 1'b0;
    m_ptr = 0; m_owner = 0; m_wcnt = 0; m_hold = '0; prev_done = 1'b0;
    m_ua = '0; m_ub = '0; acc_mask = '0;
  endtask

  task automatic monitor();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    bit           rise, n_start, n_resp;
    int unsigned  idx;
    exp_ready = '0; exp_rv = '0; n_start = 1'b0; n_resp = 1'b0; idx = 0;
    if (m_free) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (bus.req_valid[(m_ptr + k) % N]) begin
          exp_ready[(m_ptr + k) % N] = 1'b1;
          break;
        end
      end
    end
    if (m_resp) exp_rv[m_owner] = 1'b1;
    check("req_ready", bus.req_ready, exp_ready);
    check("unit_start", unit_start, m_start);
    check("busy", busy, m_start | m_wait);
    check("resp_valid", bus.resp_valid, exp_rv);
    check("resp_result", bus.resp_result, m_hold);
    check("unit_clear", unit_clear, m_resp & m_err);
    if (m_resp) begin
      check("resp_err", bus.resp_err, m_err);
      resp_log.push_back('{m_owner, bus.resp_result, bus.resp_err});
    end
    if (m_start) begin
      check("unit_a", unit_a, m_ua);
      check("unit_b", unit_b, m_ub);
    end

    rise     = unit_done && !prev_done;
    acc_mask = reset ? '0 : (exp_ready & bus.req_valid);
    if (reset) begin
      model_reset();
    end else begin
      if (m_free && acc_mask != '0) begin
        for (int unsigned j = 0; j < N; j++) if (acc_mask[j]) idx = j;
        m_owner = idx;
        m_ptr   = (idx + 1) % N;
        m_ua    = bus.req_a[idx*W +: W];
        m_ub    = bus.req_b[idx*W +: W];
        m_free  = 1'b0;
        n_start = 1'b1;
        grant_log.push_back(idx);
      end else if (m_start) begin
        m_wait = 1'b1;
        m_wcnt = 0;
      end else if (m_wait) begin
        if (rise) begin
          n_resp = 1'b1; m_err = 1'b0; m_hold = m_ua * m_ub; m_wait = 1'b0; m_free = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_wcnt == TO - 1) begin
          n_resp = 1'b1; m_err = 1'b1; m_hold = '0; m_wait = 1'b0; m_free = 1'b1;
        end else begin
          m_wcnt++;
        end
`endif
      end
      m_start   = n_start;
      m_resp    = n_resp;
      prev_done = unit_done;
    end
  endtask

  task automatic present();
    for (int unsigned i = 0; i < N; i++) begin
      if (jq[i].size() != 0 && !(withdraw_en && $urandom_range(0, 5) == 0)) begin
        bus.req_valid[i]     = 1'b1;
        bus.req_a[i*W +: W]  = jq[i][0].a;
        bus.req_b[i*W +: W]  = jq[i][0].b;
      end else begin
        bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < N; i++) if (acc_mask[i]) jq[i].delete(0);
    present();
  endtask

  function automatic int unsigned outstanding();
    int unsigned n;
    n = (m_free ? 0 : 1) + (m_resp ? 1 : 0);
    for (int unsigned i = 0; i < N; i++) n += jq[i].size();
    return n;
  endfunction

  task automatic run_until_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (outstanding() != 0) begin
      if (n == budget) begin
        check("drain_budget", outstanding(), 0);
        return;
      end
      cycle();
      n++;
    end
  endtask

  task automatic push(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    jq[i].push_back('{a, b});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_result"}, bus.resp_result, 0);
    check({tag, "_resp_err"}, bus.resp_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_unit_start"}, unit_start, 0);
    check({tag, "_unit_a"}, unit_a, 0);
    check({tag, "_unit_b"}, unit_b, 0);
    check({tag, "_unit_clear"}, unit_clear, 0);
  endtask

  task automatic reset_seq();
    reset = 1'b1;
    cycle();
    cycle();
    check_zero("rst");
    reset = 1'b0;
  endtask

  task automatic check_resp(input int unsigned k, input int unsigned owner, input logic [W-1:0] res,
                            input logic err);
    if (k < resp_log.size()) begin
      check("resp_owner", resp_log[k].owner, owner);
      check("resp_value", resp_log[k].result, res);
      check("resp_errbit", resp_log[k].err, err);
    end else begin
      check("resp_missing", resp_log.size(), k + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned njobs, snap, guard;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    withdraw_en   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_zero("por");
    reset = 1'b0;

    // single job
    push(0, 1, 2); present();
    run_until_idle(60);
    check("single_count", resp_log.size(), 1);
    check_resp(0, 0, 2, 1'b0);

    // three simultaneous requesters from a fresh pointer
    reset_seq();
    resp_log.delete();
    push(0, 7, 4); push(1, 123, 456); push(2, 1, 2); present();
    run_until_idle(100);
    check("trio_count", resp_log.size(), 3);
    check_resp(0, 0, 28, 1'b0);
    check_resp(1, 1, 56088, 1'b0);
    check_resp(2, 2, 2, 1'b0);

    // all four continuously valid for eight jobs
    reset_seq();
    grant_log.delete();
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned i = 0; i < N; i++) push(i, $urandom, $urandom);
    present();
    run_until_idle(200);
    check("rot_count", grant_log.size(), 8);
    for (int unsigned k = 0; k < grant_log.size(); k++) check("rot_order", grant_log[k], k % N);

    // stale level done between jobs
    resp_log.delete();
    push(0, 5, 6); present();
    run_until_idle(60);
    repeat (3) cycle();
    check("stale_level_high", unit_done, 1);
    push(0, 7, 4); present();
    run_until_idle(60);
    check("stale_count", resp_log.size(), 2);
    check_resp(1, 0, 28, 1'b0);

    // reset two cycles into WAIT
    resp_log.delete();
    push(0, 9, 9); present();
    guard = 0;
    while (!m_wait && guard < 20) begin cycle(); guard++; end
    check("reached_wait", m_wait, 1);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_zero("midjob");
    snap = resp_log.size();
    repeat (8) cycle();
    check("no_resp_after_reset", resp_log.size(), snap);
    push(0, 123, 456); present();
    run_until_idle(60);
    check_resp(snap, 0, 56088, 1'b0);

    // randomized mix with requesters occasionally withdrawing
    withdraw_en = 1'b1;
    for (int unsigned r = 0; r < 6; r++) begin
      resp_log.delete();
      njobs = 0;
      for (int unsigned i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int unsigned j = 0; j <= $urandom_range(0, 2); j++) begin
            push(i, $urandom, $urandom);
            njobs++;
          end
        end
      end
      present();
      run_until_idle(60 * njobs + 20);
      check("rand_resp_count", resp_log.size(), njobs);
      repeat ($urandom_range(0, 3)) cycle();
    end
    withdraw_en = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // unit never completes: watchdog response, then normal service resumes
    resp_log.delete();
    never_done = 1'b1;
    push(2, 11, 13); present();
    run_until_idle(80);
    check_resp(0, 2, 0, 1'b1);
    never_done = 1'b0;
    push(3, 11, 13); present();
    run_until_idle(60);
    check_resp(1, 3, 143, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_unit_arbiter.md
# mul_unit_arbiter

Shares a single start/done sequential compute unit (the generated `f` multiply-by-loop block: `a`, `b` in, `result`/`done` out) among N requesters. Each requester presents operands on a valid/ready handshake. The arbiter grants round-robin, drives one `start` pulse and captures the unit's result on completion. It routes the result back to the owning requester with a one-cycle response pulse. It sits between requester FSMs and one unit instance; the unit shares `clk` and `reset`.

## Interface
Parameters:
- `N`, 4: number of requesters (2..16).
- `W`, 32: operand/result width.
- `TIMEOUT`, 1024: watchdog limit in cycles (used only with `ARB_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N: per-requester request; operands must be held stable until accepted.
- `req_a`, `req_b` in N*W: packed operands; requester i uses bits [i*W +: W].
- `req_ready` out N: one-hot grant; accept occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid` out N: one-cycle pulse to the owner when its job completes.
- `resp_result` out W: result; valid while any `resp_valid` bit is high, held until the next response.
- `resp_err` out 1: qualifies `resp_valid`; 1 means timeout.
- `busy` out 1: high in START and WAIT.
- `unit_start` out 1: one-cycle start pulse to the unit.
- `unit_a`, `unit_b` out W: latched operands, stable from START until the next accept.
- `unit_done` in 1: unit completion; pulse or level.
- `unit_result` in W: unit result, sampled at completion.
- `unit_clear` out 1: one-cycle unit abort, OR'd into the unit reset by the integrator.

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE:
  - `req_ready` is combinational. It is one-hot at the first asserted `req_valid` index at or after `ptr` (cyclic order), and 0 if none are valid.
  - On accept, latch `unit_a`/`unit_b` and `owner` = granted index.
  - Set `ptr` = (owner+1) mod N, then go to START.
- START: `unit_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: completion is a rising edge of `unit_done` (`unit_done` & !`done_q`, where `done_q` is registered every cycle).
  - On completion, register `resp_result` = `unit_result`, `resp_err`=0 and `resp_valid[owner]`=1 for one cycle.
  - Then go to IDLE.
- The rising-edge rule makes a level-style `done` left high from the previous job harmless.
- `req_ready` is 0 in START and WAIT. Requests are never dropped; they wait.
- No arithmetic in the arbiter; `W` bits are passed through unmodified.

## Timing
- Reset values: state IDLE, `ptr`=0, `owner`=0, `done_q`=0.
  - All outputs are 0: `req_ready`, `resp_valid`, `resp_result`, `resp_err`, `busy`, `unit_start`, `unit_a`, `unit_b`, `unit_clear`.
- Latency:
  - Accept at edge k gives `unit_start` high in cycle k+1.
  - Done rising edge seen in cycle m gives `resp_valid` high in cycle m+1.
- Back-to-back: the arbiter is in IDLE during the `resp_valid` cycle, so a pending request is accepted in that same cycle. Overhead is 2 cycles + unit latency per job.
- Simultaneous valid: the lowest index at/after `ptr` wins. With all N valid continuously, grants rotate 0,1,...,N-1,0.
- Requester drops `req_valid` before grant: no effect, no state change.
- `unit_done` high during IDLE/START: ignored, except that it updates `done_q`.
- Reset mid-job: immediate return to reset values with no response issued. The unit is reset by the same `reset`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A cycle counter clears on entering WAIT.
  - If it reaches `TIMEOUT` without completion: `resp_valid[owner]`=1, `resp_err`=1, `resp_result`=0 and `unit_clear`=1, all for one cycle. Then go to IDLE.
  - A completion in the same cycle as the timeout wins; this is a normal response.
- `ARB_TIMEOUT_EN` undefined: no counter; `resp_err` and `unit_clear` are tied 0; WAIT never exits except on completion or reset.

## Structure
- Package `mul_arb_pkg`: state enum (IDLE, START, WAIT) and default constants for N, W and TIMEOUT.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` [N], `ptr` [$clog2(N)].
  - Outputs: one-hot `grant` [N], `any`.
  - Reusable by other sharers.

## Test plan
Bench: the unit is a behavioural multiplier, `done` a level high 5 cycles after `start` until the next start.
- Single requester 0, a=1, b=2 -> `unit_start` 1 cycle after accept, `resp_valid[0]` pulse, `resp_result`=2, `resp_err`=0.
- Requesters 0,1,2 valid together: (7,4), (123,456), (1,2) -> responses in order 0,1,2 with 28, 56088, 2; each `resp_valid` pulse is exactly 1 cycle.
- All 4 valid continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3; the next grant lands in the same cycle as the previous `resp_valid`.
- Stale done: the unit holds `done` high between jobs; second job a=7, b=4 -> no early response, `resp_result`=28 only after a new rising edge.
- Reset asserted 2 cycles into WAIT -> all outputs 0 next cycle, no `resp_valid`; a post-reset job a=123, b=456 returns 56088.
- With `ARB_TIMEOUT_EN`, TIMEOUT=16 and the unit never raising `done` -> after 16 WAIT cycles `resp_valid[owner]`=1, `resp_err`=1, `resp_result`=0, `unit_clear` pulse; the next request is accepted.
